// File: rtl/pe_pkg.sv
// pe_pkg: shared constants for the parametrised systolic processing element.
// Holds the dataflow encodings and the default datapath widths.
package pe_pkg;

  localparam logic DF_OS = 1'b0;
  localparam logic DF_WS = 1'b1;

  localparam int A_W_DEF  = 8;
  localparam int B_W_DEF  = 19;
  localparam int C_W_DEF  = 19;
  localparam int SH_W_DEF = 6;

endpackage

// File: rtl/pe_round_shift.sv
// pe_round_shift: combinational rounding arithmetic right shift used on the
// output-stationary drain path. Rounds half up (toward +inf) by adding
// 2^(s-1) before the shift, evaluated one bit wider so the bias never
// overflows. A shift of C_W or more drains to zero.
module pe_round_shift
  import pe_pkg::*;
#(
  parameter int C_W  = C_W_DEF,
  parameter int SH_W = SH_W_DEF
) (
  input  logic signed [C_W-1:0]  x,
  input  logic        [SH_W-1:0] sh,
  output logic signed [C_W-1:0]  y
);

  function automatic logic signed [C_W-1:0] round_shift(
    input logic signed [C_W-1:0]  val,
    input logic        [SH_W-1:0] s
  );
    logic signed [C_W:0]  ext;
    logic signed [C_W:0]  half;
    logic signed [C_W:0]  sum;
    logic        [SH_W-1:0] s_m1;
    logic signed [C_W-1:0] res;
    ext  = {val[C_W-1], val};
    s_m1 = s - SH_W'(1);
    half = '0;
    half[0] = 1'b1;
    half = half << s_m1;
    sum  = ext + half;
    sum  = sum >>> s;
    if (s == '0) begin
      res = val;
    end else if (int'(s) >= C_W) begin
      res = '0;
    end else begin
      res = sum[C_W-1:0];
    end
    return res;
  endfunction

  assign y = round_shift(x, sh);

endmodule

// File: rtl/pe_param.sv
// pe_param: parametrised systolic PE supporting output-stationary (OS) and
// weight-stationary (WS) dataflows with double-buffered c1/c2 registers
// selected by the propagate bit. Results drained in OS mode pass through a
// rounding arithmetic right shift applied only on a propagate flip.
// Optional macro PE_IO_REG_EN adds one register stage on every input and
// every output (latency 3 instead of 1).
module pe_param
  import pe_pkg::*;
#(
  parameter int A_W  = A_W_DEF,
  parameter int B_W  = B_W_DEF,
  parameter int C_W  = C_W_DEF,
  parameter int SH_W = SH_W_DEF
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic signed [A_W-1:0]  in_a,
  input  logic signed [B_W-1:0]  in_b,
  input  logic signed [C_W-1:0]  in_d,
  input  logic                   in_valid,
  input  logic                   in_propagate,
  input  logic        [SH_W-1:0] in_shift,
  input  logic                   in_dataflow,
  output logic signed [A_W-1:0]  out_a,
  output logic signed [B_W-1:0]  out_b,
  output logic signed [C_W-1:0]  out_c,
  output logic                   out_valid,
  output logic                   out_propagate,
  output logic        [SH_W-1:0] out_shift,
  output logic                   out_dataflow
);

  localparam int AB_W  = A_W + B_W;
  localparam int AC_W  = A_W + C_W;
  localparam int ACC_W = ((AB_W > C_W) ? AB_W : C_W) + 1;
  localparam int WSB_W = ((AC_W > B_W) ? AC_W : B_W) + 1;

  // core input beat
  logic signed [A_W-1:0]  a_p0;
  logic signed [B_W-1:0]  b_p0;
  logic signed [C_W-1:0]  d_p0;
  logic                   vld_p0;
  logic                   prop_p0;
  logic        [SH_W-1:0] shift_p0;
  logic                   df_p0;

  // core output registers
  logic signed [A_W-1:0]  a_p1;
  logic signed [B_W-1:0]  b_p1;
  logic signed [C_W-1:0]  c_p1;
  logic                   vld_p1;
  logic                   prop_p1;
  logic        [SH_W-1:0] shift_p1;
  logic                   df_p1;

  // double-buffered accumulator/weight state
  logic signed [C_W-1:0]  c1;
  logic signed [C_W-1:0]  c2;
  logic                   last_prop;

  // ---- stage p0: optional input boundary registers ----
`ifdef PE_IO_REG_EN
  // Register every input so a standalone PE closes timing from its ports.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      a_p0     <= '0;
      b_p0     <= '0;
      d_p0     <= '0;
      vld_p0   <= 1'b0;
      prop_p0  <= 1'b0;
      shift_p0 <= '0;
      df_p0    <= 1'b0;
    end else begin
      a_p0     <= in_a;
      b_p0     <= in_b;
      d_p0     <= in_d;
      vld_p0   <= in_valid;
      prop_p0  <= in_propagate;
      shift_p0 <= in_shift;
      df_p0    <= in_dataflow;
    end
  end
`else
  assign a_p0     = in_a;
  assign b_p0     = in_b;
  assign d_p0     = in_d;
  assign vld_p0   = in_valid;
  assign prop_p0  = in_propagate;
  assign shift_p0 = in_shift;
  assign df_p0    = in_dataflow;
`endif

  // core datapath
  logic                   flip;
  logic        [SH_W-1:0] offset;
  logic signed [AB_W-1:0] prod_ab;
  logic signed [C_W-1:0]  ws_w;
  logic signed [AC_W-1:0] prod_aw;
  logic signed [ACC_W-1:0] c1_acc_w;
  logic signed [ACC_W-1:0] c2_acc_w;
  logic signed [WSB_W-1:0] ws_sum_w;
  logic signed [C_W-1:0]  drain;
  logic signed [C_W-1:0]  drain_sh;
  logic signed [C_W-1:0]  c_nxt;
  logic signed [B_W-1:0]  b_nxt;

  // The shift is only meaningful on the beat where the buffers swap roles.
  assign flip   = (prop_p0 != last_prop);
  assign offset = flip ? shift_p0 : '0;

  assign prod_ab  = AB_W'(a_p0) * AB_W'(b_p0);
  assign c1_acc_w = ACC_W'(c1) + ACC_W'(prod_ab);
  assign c2_acc_w = ACC_W'(c2) + ACC_W'(prod_ab);

  // In WS the buffer not being preloaded holds the active weight.
  assign ws_w     = prop_p0 ? c2 : c1;
  assign prod_aw  = AC_W'(a_p0) * AC_W'(ws_w);
  assign ws_sum_w = WSB_W'(b_p0) + WSB_W'(prod_aw);

  assign drain = prop_p0 ? c1 : c2;

  pe_round_shift #(
    .C_W  (C_W),
    .SH_W (SH_W)
  ) u_round_shift (
    .x  (drain),
    .sh (offset),
    .y  (drain_sh)
  );

  assign c_nxt = (df_p0 == DF_WS) ? drain : drain_sh;
  assign b_nxt = (df_p0 == DF_WS) ? ws_sum_w[B_W-1:0] : b_p0;

  // Buffer state advances only on qualified beats; sums wrap to C_W.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      c1        <= '0;
      c2        <= '0;
      last_prop <= 1'b0;
    end else if (vld_p0) begin
      last_prop <= prop_p0;
      if (df_p0 == DF_OS) begin
        if (prop_p0) begin
          c1 <= d_p0;
          c2 <= c2_acc_w[C_W-1:0];
        end else begin
          c2 <= d_p0;
          c1 <= c1_acc_w[C_W-1:0];
        end
      end else begin
        if (prop_p0) begin
          c1 <= d_p0;
        end else begin
          c2 <= d_p0;
        end
      end
    end
  end

  // ---- stage p1: core output registers (load every cycle) ----
  // Data and control copies move together to keep the systolic skew aligned.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      a_p1     <= '0;
      b_p1     <= '0;
      c_p1     <= '0;
      vld_p1   <= 1'b0;
      prop_p1  <= 1'b0;
      shift_p1 <= '0;
      df_p1    <= 1'b0;
    end else begin
      a_p1     <= a_p0;
      b_p1     <= b_nxt;
      c_p1     <= c_nxt;
      vld_p1   <= vld_p0;
      prop_p1  <= prop_p0;
      shift_p1 <= shift_p0;
      df_p1    <= df_p0;
    end
  end

  // ---- stage p2: optional output boundary registers ----
`ifdef PE_IO_REG_EN
  // Extra output flop isolates the core from downstream routing.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      out_a         <= '0;
      out_b         <= '0;
      out_c         <= '0;
      out_valid     <= 1'b0;
      out_propagate <= 1'b0;
      out_shift     <= '0;
      out_dataflow  <= 1'b0;
    end else begin
      out_a         <= a_p1;
      out_b         <= b_p1;
      out_c         <= c_p1;
      out_valid     <= vld_p1;
      out_propagate <= prop_p1;
      out_shift     <= shift_p1;
      out_dataflow  <= df_p1;
    end
  end
`else
  assign out_a         = a_p1;
  assign out_b         = b_p1;
  assign out_c         = c_p1;
  assign out_valid     = vld_p1;
  assign out_propagate = prop_p1;
  assign out_shift     = shift_p1;
  assign out_dataflow  = df_p1;
`endif

endmodule
